// File: rtl/i2s_tx_pkg.sv
// Shared types and sizing for the I2S transmit engine.
// Holds the FSM state encoding and the default frame geometry.
// Optional feature macro used by the engine: I2S_TX_UNDERRUN_HOLD_EN.
package i2s_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int SAMPLE_W_DEF = 16;
  localparam int FRAME_W      = 2 * SAMPLE_W_DEF;
  localparam int BCNT_W       = $clog2(FRAME_W);

endpackage

// File: rtl/i2s_tx_engine_sck_gen.sv
// SCK generator: half-period of clk_div+1 clk cycles, with rise/fall event strobes.
// Latency: first toggle clk_div+1 cycles after run rises; events are combinational.
// No backpressure; run=0 holds sck low and the divider at zero.
module i2s_sck_gen
  import i2s_tx_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             run,
  output logic             sck,
  output logic             rise_evt,
  output logic             fall_evt
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_lim_q, div_lim_d;
  logic             sck_q, sck_d;
  logic             tc;

  assign tc       = run && (div_cnt_q == div_lim_q);
  assign rise_evt = tc && !sck_q;
  assign fall_evt = tc && sck_q;
  assign sck      = sck_q;

  // Count up to the captured limit; the limit is only refreshed while stopped or at terminal count
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    div_lim_d = div_lim_q;
    sck_d     = sck_q;
    if (!run) begin
      div_cnt_d = '0;
      div_lim_d = clk_div;
      sck_d     = 1'b0;
    end else if (tc) begin
      div_cnt_d = '0;
      div_lim_d = clk_div;
      sck_d     = ~sck_q;
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      div_lim_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      div_lim_q <= div_lim_d;
      sck_q     <= sck_d;
    end
  end

endmodule

// File: rtl/i2s_tx_engine.sv
// Master-mode Philips I2S transmitter: pops one {left,right} word per frame, MSB first.
// Latency: first pop on the first SCK fall after enable; outputs change only on SCK falls.
// No backpressure on the serial side; an empty FIFO at frame load sends a filler frame and pulses underrun.
// Define I2S_TX_UNDERRUN_HOLD_EN to repeat the last popped word on underrun instead of zeros.
module i2s_tx_engine
  import i2s_tx_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DIV_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DIV_W-1:0]      clk_div,
  input  logic [2*SAMPLE_W-1:0] fifo_data,
  input  logic                  fifo_valid,
  output logic                  fifo_ack,
  output logic                  i2s_sck,
  output logic                  i2s_ws,
  output logic                  i2s_sd,
  output logic                  underrun,
  output logic                  busy
);

  localparam int FRM_W = 2 * SAMPLE_W;
  localparam int BC_W  = $clog2(FRM_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRM_W - 1);
  localparam logic [BC_W-1:0] WS_LO   = BC_W'(SAMPLE_W - 1);
  localparam logic [BC_W-1:0] WS_HI   = BC_W'(FRM_W - 2);

  state_e             state_q, state_d;
  logic [BC_W-1:0]    bit_q, bit_d, bit_nxt;
  logic [FRM_W-1:0]   shift_q, shift_d;
  logic               ws_q, ws_d;
  logic               sd_q, sd_d;
  logic               ack_q, ack_d;
  logic               und_q, und_d;
  logic               fall_evt;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  logic [FRM_W-1:0]   last_q, last_d;
`endif

  i2s_sck_gen #(
    .DIV_W (DIV_W)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_div  (clk_div),
    .run      (state_q != ST_IDLE),
    .sck      (i2s_sck),
    .rise_evt (),
    .fall_evt (fall_evt)
  );

  assign fifo_ack = ack_q;
  assign underrun = und_q;
  assign i2s_ws   = ws_q;
  assign i2s_sd   = sd_q;
  assign busy     = (state_q != ST_IDLE);

  // Run/drain control plus per-SCK-fall bit sequencing, frame load and serial output
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    ack_d   = 1'b0;
    und_d   = 1'b0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    last_d  = last_q;
`endif
    bit_nxt = (bit_q == BC_LAST) ? '0 : bit_q + BC_W'(1);

    case (state_q)
      ST_IDLE:  if (enable)  state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: if (enable)  state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && fall_evt) begin
      if ((state_q == ST_DRAIN) && !enable && (bit_q == BC_LAST)) begin
        // Frame finished while stopping: park the line, no pop
        state_d = ST_IDLE;
        bit_d   = BC_LAST;
        ws_d    = 1'b1;
        sd_d    = 1'b0;
      end else begin
        bit_d = bit_nxt;
        ws_d  = (bit_nxt >= WS_LO) && (bit_nxt <= WS_HI);
        if (bit_nxt == '0) begin
          if (fifo_valid) begin
            shift_d = fifo_data;
            ack_d   = 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
            last_d  = fifo_data;
`endif
          end else begin
            und_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
            shift_d = last_q;
`else
            shift_d = '0;
`endif
          end
        end else begin
          shift_d = shift_q << 1;
        end
        sd_d = shift_d[FRM_W-1];
      end
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= BC_LAST;
      shift_q <= '0;
      ws_q    <= 1'b1;
      sd_q    <= 1'b0;
      ack_q   <= 1'b0;
      und_q   <= 1'b0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      ack_q   <= ack_d;
      und_q   <= und_d;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2s_tx_engine.sv
// Bench for i2s_tx_engine: FIFO/frame-load model feeds an expected-frame queue,
// a serial monitor rebuilds frames from SCK/WS/SD and compares.
// Honours I2S_TX_UNDERRUN_HOLD_EN in the reference model.
module tb_i2s_tx_engine;

  localparam int SW = 16;
  localparam int FW = 2 * SW;
  // WS level per bit slot (slot 0 = left MSB), packed slot0 at bit 31: high for slots SW-1..FW-2
  localparam logic [31:0] WS_PAT = 32'h0001_FFFE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  clk_div = 8'd1;
  logic [31:0] fifo_data = 32'hDEAD_BEEF;
  logic        fifo_valid = 1'b0;
  logic        fifo_ack, i2s_sck, i2s_ws, i2s_sd, underrun, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  i2s_tx_engine #(.SAMPLE_W(SW), .DIV_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clk_div    (clk_div),
    .fifo_data  (fifo_data),
    .fifo_valid (fifo_valid),
    .fifo_ack   (fifo_ack),
    .i2s_sck    (i2s_sck),
    .i2s_ws     (i2s_ws),
    .i2s_sd     (i2s_sd),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rst(input string tag);
    check_eq({tag, " sck"}, i2s_sck, 0);
    check_eq({tag, " ws"}, i2s_ws, 1);
    check_eq({tag, " sd"}, i2s_sd, 0);
    check_eq({tag, " fifo_ack"}, fifo_ack, 0);
    check_eq({tag, " underrun"}, underrun, 0);
    check_eq({tag, " busy"}, busy, 0);
  endtask

  // ---------------- FIFO + frame-load reference model ----------------
  logic [31:0] add_q[$];
  logic [31:0] fifo_m[$];
  logic [31:0] exp_q[$];
  bit          sess = 0;
  int          fall_n = 0;
  bit          have_load = 0;
  int          last_load_cyc = 0;
  logic [31:0] last_pop = 0;
  logic        en_h1 = 0, en_h2 = 0, rst_h1 = 0, sck_pa = 0;

  // Inputs change just after posedges, so the value seen at the previous negedge
  // is what the DUT sampled on the posedge in between.
  always @(negedge clk) begin
    logic [31:0] expw;
    bit          load_pt;
    bit          avail;
    load_pt = 0;
    if (!rst_n) begin
      sess      = 0;
      have_load = 0;
      last_pop  = 0;
      exp_q.delete();
    end else begin
      if (!sess && en_h1 && rst_h1) begin
        sess      = 1;
        fall_n    = 0;
        have_load = 0;
      end
      if (sess && sck_pa && !i2s_sck) begin
        fall_n++;
        if ((fall_n - 1) % FW == 0) begin
          if (!en_h1 && !en_h2) begin
            sess = 0;
            check_eq("stop ws", i2s_ws, 1);
            check_eq("stop sd", i2s_sd, 0);
          end else begin
            load_pt = 1;
            avail   = (fifo_m.size() > 0);
            if (avail) begin
              expw     = fifo_m.pop_front();
              last_pop = expw;
            end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
              expw = last_pop;
`else
              expw = 32'h0;
`endif
            end
            check_eq("fifo_ack at load", fifo_ack, avail);
            check_eq("underrun at load", underrun, !avail);
            check_eq("sd msb at load", i2s_sd, expw[31]);
            check_eq("ws low at load", i2s_ws, 0);
            if (have_load) check_eq("load spacing", cyc - last_load_cyc, 2 * FW * (int'(clk_div) + 1));
            have_load     = 1;
            last_load_cyc = cyc;
            exp_q.push_back(expw);
          end
        end
      end
    end
    if ((fifo_ack || underrun) && !load_pt)
      check_eq("stray ack/underrun", {30'h0, fifo_ack, underrun}, 0);
    while (add_q.size() > 0) fifo_m.push_back(add_q.pop_front());
    fifo_valid = (fifo_m.size() > 0);
    fifo_data  = fifo_valid ? fifo_m[0] : 32'hDEAD_BEEF;
    en_h2  = en_h1;
    en_h1  = enable;
    rst_h1 = rst_n;
    sck_pa = i2s_sck;
  end

  // ---------------- serial monitor / scoreboard ----------------
  int          rise_n = 0;
  int          last_rise_cyc = -100000;
  logic        sck_pb = 0;
  logic [31:0] got_w = 0, ws_w = 0, cur_exp = 0;
  bit          have_exp = 0;

  // Receiver view: sample WS/SD on SCK rising edges; the first rise of a run precedes any data
  always @(negedge clk) begin
    int per;
    int b;
    per = 2 * (int'(clk_div) + 1);
    if (!rst_n) begin
      rise_n        = 0;
      last_rise_cyc = -100000;
    end else if (!sck_pb && i2s_sck) begin
      if (cyc - last_rise_cyc > per) begin
        rise_n = 1;
      end else begin
        rise_n++;
        check_eq("sck period", cyc - last_rise_cyc, per);
      end
      last_rise_cyc = cyc;
      if (rise_n >= 2) begin
        b = (rise_n - 2) % FW;
        if (b == 0) begin
          have_exp = (exp_q.size() > 0);
          if (have_exp) cur_exp = exp_q.pop_front();
        end
        got_w = {got_w[30:0], i2s_sd};
        ws_w  = {ws_w[30:0], i2s_ws};
        if (b == FW - 1) begin
          check_eq("frame has expected word", have_exp, 1);
          check_eq("sd frame", got_w, cur_exp);
          check_eq("ws frame", ws_w, WS_PAT);
        end
      end
    end
    sck_pb = i2s_sck;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input int maxc);
    int k;
    k = 0;
    while (!fifo_ack && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check_eq("ack within budget", k < maxc, 1);
  endtask

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    while (busy && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check_eq("idle within budget", k < maxc, 1);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    enable  = 1'b0;
    clk_div = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    check_rst("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single word then underrun frames
    add_q.push_back(32'hA5A5_3C3C);
    tick(2);
    enable = 1'b1;
    wait_ack(200);
    tick(3 * 128 + 40);

    // Four words arriving mid-frame, sent back to back
    for (int i = 0; i < 4; i++) add_q.push_back({16'(2 * i + 1), 16'(2 * i + 2)});
    tick(4 * 128 + 64);

    // Stop during bit 5 of the left channel
    add_q.push_back($urandom);
    wait_ack(300);
    tick(22);
    enable = 1'b0;
    wait_idle(400);
    check_eq("stopped sck", i2s_sck, 0);
    check_eq("stopped ws", i2s_ws, 1);
    check_eq("stopped sd", i2s_sd, 0);
    check_eq("stopped busy", busy, 0);
    tick(300);

    // Asynchronous reset mid-frame, restart straight out of reset
    for (int i = 0; i < 3; i++) add_q.push_back($urandom);
    enable = 1'b1;
    wait_ack(300);
    tick(37);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_rst("async reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_ack(300);
    tick(2 * 128);
    enable = 1'b0;
    wait_idle(600);

    // Known word followed by an empty FIFO
    add_q.push_back(32'h1234_5678);
    tick(2);
    enable = 1'b1;
    wait_ack(300);
    tick(2 * 128);
    enable = 1'b0;
    wait_idle(600);

    // Randomised sessions: divider, word count, and an optional enable glitch
    for (int s = 0; s < 5; s++) begin
      clk_div = 8'($urandom_range(0, 3));
      n = int'($urandom_range(0, 4));
      for (int i = 0; i < n; i++) add_q.push_back($urandom);
      tick(3);
      enable = 1'b1;
      tick((n + 1) * 64 * (int'(clk_div) + 1) + int'($urandom_range(0, 100)));
      if ($urandom_range(0, 1) == 1) begin
        enable = 1'b0;
        tick(int'($urandom_range(1, 20)));
        enable = 1'b1;
        add_q.push_back($urandom);
        tick(2 * 64 * (int'(clk_div) + 1));
      end
      enable = 1'b0;
      wait_idle(2 * 64 * 4 + 50);
      tick(5);
    end

    tick(20);
    check_eq("frames left unchecked", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
